// File: rtl/excitation_load_driver.sv
// excitation_load_driver
//
// Envelope-detects bursts on a bit-serial excitation waveform and drives a
// thermometer-coded bank of load cells. The bank is ramped up and down in
// RAMP_STEP increments, one step every RAMP_DIV cycles, to bound di/dt.
// An optional watchdog caps the time spent at full load.
//
// Build option: define EXCITE_WDOG_EN to enable the ON-time watchdog, the
// sticky fault flag and the COOL cool-down period. Without it, fault is 0,
// COOL is never entered and ON lasts as long as the burst does.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   mmcm_locked  clock-good; low aborts to IDLE with the bank off
//   sig_in       serial excitation waveform
//   arm          enable; low drops the envelope and ramps the bank down
//   fault_clr    one-cycle pulse clearing fault
//   load_en      thermometer enables, bit i = (i < level)
//   busy         FSM is not in IDLE
//   fault        sticky watchdog trip flag
//   active_cnt   saturating count of cycles with a nonzero level
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | bank off, waiting for a burst
// RAMP_UP   | adding RAMP_STEP cells every RAMP_DIV cycles
// ON        | full bank; watchdog counting when enabled
// RAMP_DOWN | removing RAMP_STEP cells every RAMP_DIV cycles
// COOL      | bank off, bursts ignored for COOLDOWN cycles after a trip

module excitation_load_driver #(
  parameter int N_CELLS   = 64,
  parameter int RAMP_STEP = 8,
  parameter int RAMP_DIV  = 4,
  parameter int HOLD      = 16,
  parameter int MAX_ON    = 1024,
  parameter int COOLDOWN  = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mmcm_locked,
  input  logic               sig_in,
  input  logic               arm,
  input  logic               fault_clr,
  output logic [N_CELLS-1:0] load_en,
  output logic               busy,
  output logic               fault,
  output logic [31:0]        active_cnt
);

  localparam int LW = $clog2(N_CELLS + 1);
  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int HW = $clog2(HOLD + 1);

  localparam logic [LW-1:0] L_STEP   = LW'(RAMP_STEP);
  localparam logic [LW-1:0] L_FULL   = LW'(N_CELLS);
  localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RAMP_UP   = 3'd1;
  localparam logic [2:0] S_ON        = 3'd2;
  localparam logic [2:0] S_RAMP_DOWN = 3'd3;
  localparam logic [2:0] S_COOL      = 3'd4;

  generate
    if ((RAMP_STEP < 1) || ((N_CELLS % RAMP_STEP) != 0) || (RAMP_DIV < 1) ||
        (HOLD < 2) || (MAX_ON < 1) || (COOLDOWN < 1)) begin : g_bad_param
      $error("excitation_load_driver: illegal parameter set");
    end
  endgenerate

  logic [2:0]    r_state;
  logic [LW-1:0] r_level;
  logic [DW-1:0] r_div_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic          r_sig_d;

  logic [2:0]         w_state_nxt;
  logic [LW-1:0]      w_level_nxt;
  logic [DW-1:0]      w_div_nxt;
  logic [LW-1:0]      w_lvl_up;
  logic [LW-1:0]      w_lvl_dn;
  logic               w_rise;
  logic               w_burst;
  logic               w_tick;
  logic               w_trip;
  logic               w_trip_pend;
  logic               w_cool_done;
  logic [N_CELLS-1:0] w_therm;

  assign w_rise   = sig_in & ~r_sig_d;
  assign w_burst  = (r_hold_cnt != '0) & arm;
  assign w_tick   = (r_div_cnt == DIV_LAST);
  assign w_lvl_up = r_level + L_STEP;
  // Clamp at zero so the level can never wrap below an empty bank.
  assign w_lvl_dn = (r_level > L_STEP) ? (r_level - L_STEP) : '0;
  assign busy     = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    if (!mmcm_locked) begin
      w_state_nxt = S_IDLE;
      w_level_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_burst) begin
            w_level_nxt = L_STEP;
            w_state_nxt = (L_STEP >= L_FULL) ? S_ON : S_RAMP_UP;
          end
        end
        S_RAMP_UP: begin
          if (!w_burst) begin
            w_level_nxt = w_lvl_dn;
            w_state_nxt = (w_lvl_dn == '0) ? S_IDLE : S_RAMP_DOWN;
          end else if (w_tick) begin
            if (w_lvl_up >= L_FULL) begin
              w_level_nxt = L_FULL;
              w_state_nxt = S_ON;
            end else begin
              w_level_nxt = w_lvl_up;
            end
          end
        end
        S_ON: begin
          if (w_trip) begin
            w_level_nxt = w_lvl_dn;
            w_state_nxt = (w_lvl_dn == '0) ? S_COOL : S_RAMP_DOWN;
          end else if (!w_burst) begin
            w_level_nxt = w_lvl_dn;
            w_state_nxt = (w_lvl_dn == '0) ? S_IDLE : S_RAMP_DOWN;
          end
        end
        S_RAMP_DOWN: begin
          // A returning burst resumes the ramp from the current level, but
          // not while a watchdog trip is still being serviced.
          if (w_burst && !w_trip_pend) begin
            w_state_nxt = S_RAMP_UP;
          end else if (w_tick) begin
            w_level_nxt = w_lvl_dn;
            if (w_lvl_dn == '0) begin
              w_state_nxt = w_trip_pend ? S_COOL : S_IDLE;
            end
          end
        end
        S_COOL: begin
          w_level_nxt = '0;
          if (w_cool_done) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_level_nxt = '0;
        end
      endcase
    end
    // The step divider restarts on every state change so each state sees a
    // full RAMP_DIV period before its first step.
    w_div_nxt = ((w_state_nxt != r_state) || w_tick) ? '0 : (r_div_cnt + 1'b1);
  end

  always_comb begin
    w_therm = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      w_therm[i] = (32'(r_level) > i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_level   <= '0;
      r_div_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_level   <= w_level_nxt;
      r_div_cnt <= w_div_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_d    <= 1'b0;
      r_hold_cnt <= '0;
      load_en    <= '0;
      active_cnt <= '0;
    end else begin
      r_sig_d <= sig_in;
      if (!mmcm_locked) begin
        r_hold_cnt <= '0;
      end else if (w_rise) begin
        r_hold_cnt <= HOLD_LD;
      end else if (r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
      // Clearing load_en directly on abort turns the bank off one cycle
      // sooner than waiting for the level register to propagate.
      load_en <= mmcm_locked ? w_therm : '0;
      if ((r_level != '0) && (active_cnt != '1)) begin
        active_cnt <= active_cnt + 32'd1;
      end
    end
  end

`ifdef EXCITE_WDOG_EN
  localparam int OW = (MAX_ON > 1) ? $clog2(MAX_ON) : 1;
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [OW-1:0] ON_LAST = OW'(MAX_ON - 1);
  localparam logic [CW-1:0] COOL_LD = CW'(COOLDOWN - 1);

  logic [OW-1:0] r_on_cnt;
  logic [CW-1:0] r_cool_cnt;
  logic          r_trip_pend;
  logic          r_fault;

  assign w_trip      = mmcm_locked && (r_state == S_ON) && (r_on_cnt == ON_LAST);
  assign w_trip_pend = r_trip_pend;
  assign w_cool_done = (r_cool_cnt == '0);
  assign fault       = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_on_cnt    <= '0;
      r_cool_cnt  <= '0;
      r_trip_pend <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_on_cnt <= ((r_state == S_ON) && (w_state_nxt == S_ON)) ? (r_on_cnt + 1'b1) : '0;
      // Down-counter loaded on COOL entry; COOL exits the cycle it reads 0.
      if (w_state_nxt == S_COOL) begin
        r_cool_cnt <= (r_state == S_COOL) ? (r_cool_cnt - 1'b1) : COOL_LD;
      end else begin
        r_cool_cnt <= '0;
      end
      if (w_trip) begin
        r_trip_pend <= 1'b1;
      end else if (w_state_nxt == S_IDLE) begin
        r_trip_pend <= 1'b0;
      end
      // A trip in the same cycle as fault_clr leaves fault set.
      if (w_trip) begin
        r_fault <= 1'b1;
      end else if (fault_clr) begin
        r_fault <= 1'b0;
      end
    end
  end
`else
  logic w_unused_fault_clr;

  assign w_trip             = 1'b0;
  assign w_trip_pend        = 1'b0;
  assign w_cool_done        = 1'b1;
  assign fault              = 1'b0;
  assign w_unused_fault_clr = fault_clr;
`endif

endmodule

// File: tb/tb_excitation_load_driver.sv
module tb_excitation_load_driver;

  logic        clk;
  logic        rst_n;
  logic        mmcm_locked;
  logic        sig_in;
  logic        arm;
  logic        fault_clr;
  logic [63:0] load_en;
  logic        busy;
  logic        fault;
  logic [31:0] active_cnt;

  int n_pass;
  int n_total;

  excitation_load_driver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mmcm_locked (mmcm_locked),
    .sig_in      (sig_in),
    .arm         (arm),
    .fault_clr   (fault_clr),
    .load_en     (load_en),
    .busy        (busy),
    .fault       (fault),
    .active_cnt  (active_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] therm(input int n);
    logic [63:0] t;
    t = '0;
    for (int i = 0; i < n; i++) t[i] = 1'b1;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    mmcm_locked = 1'b1;
    sig_in      = 1'b0;
    arm         = 1'b1;
    fault_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_total++;
    if (load_en !== 64'd0 || busy !== 1'b0 || fault !== 1'b0 || active_cnt !== 32'd0)
      $display("FAIL reset outputs: load_en=%h busy=%b fault=%b active_cnt=%0d, want 0/0/0/0",
               load_en, busy, fault, active_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      sig_in = (k % 2 == 0);
      tick();
    end
    n_total++;
    if (load_en !== therm(24)) $display("FAIL midramp_level load_en got %h want %h", load_en, therm(24));
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (load_en !== 64'd0 || busy !== 1'b0 || active_cnt !== 32'd0 || fault !== 1'b0)
      $display("FAIL midramp_async_rst: load_en=%h busy=%b active_cnt=%0d fault=%b, want all 0",
               load_en, busy, active_cnt, fault);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      sig_in = (k % 2 == 0);
      tick();
    end
    n_total++;
    if (load_en !== 64'd0 || busy !== 1'b0)
      $display("FAIL midramp_held_rst: load_en=%h busy=%b, want 0/0", load_en, busy);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_burst();
    int el, eb, ea;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      sig_in = (k < 48) && (k % 2 == 0);
      tick();
      el = -1; eb = -1; ea = -1;
      case (k)
        1:  begin el = 0;  eb = 1; end
        2:  el = 8;
        5:  el = 8;
        6:  el = 16;
        29: el = 56;
        30: el = 64;
        63: el = 64;
        64: el = 56;
        67: el = 56;
        68: el = 48;
        90: eb = 1;
        91: begin el = 8; eb = 0; end
        92: el = 0;
        99: ea = 90;
        default: ;
      endcase
      if (el >= 0) begin
        n_total++;
        if (load_en !== therm(el)) $display("FAIL burst_load k=%0d got %h want %h", k, load_en, therm(el));
        else n_pass++;
      end
      if (eb >= 0) begin
        n_total++;
        if (busy !== eb[0]) $display("FAIL burst_busy k=%0d got %b want %0d", k, busy, eb);
        else n_pass++;
      end
      if (ea >= 0) begin
        n_total++;
        if (active_cnt !== 32'(ea)) $display("FAIL burst_active_cnt got %0d want %0d", active_cnt, ea);
        else n_pass++;
      end
    end
  endtask

  task automatic test_resume();
    int el;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      sig_in = ((k < 8) || (k >= 28 && k < 60)) && (k % 2 == 0);
      tick();
      el = -1;
      case (k)
        23: el = 48;
        24: el = 40;
        27: el = 40;
        28: el = 32;
        30: el = 32;
        33: el = 32;
        34: el = 40;
        38: el = 48;
        default: ;
      endcase
      if (el >= 0) begin
        n_total++;
        if (load_en !== therm(el)) $display("FAIL resume_load k=%0d got %h want %h", k, load_en, therm(el));
        else n_pass++;
      end
    end
  endtask

  task automatic test_mmcm_abort();
    do_reset();
    for (int k = 0; k < 47; k++) begin
      sig_in      = (k % 2 == 0);
      mmcm_locked = !(k >= 40 && k < 43);
      tick();
      if (k == 39) begin
        n_total++;
        if (load_en !== therm(64)) $display("FAIL mmcm_before got %h want %h", load_en, therm(64));
        else n_pass++;
      end
      if (k == 40) begin
        n_total++;
        if (load_en !== 64'd0 || busy !== 1'b0 || fault !== 1'b0)
          $display("FAIL mmcm_abort load_en=%h busy=%b fault=%b want 0/0/0", load_en, busy, fault);
        else n_pass++;
      end
      if (k == 41) begin
        n_total++;
        if (active_cnt !== 32'd39) $display("FAIL mmcm_active_cnt got %0d want 39", active_cnt);
        else n_pass++;
      end
      if (k == 44) begin
        n_total++;
        if (busy !== 1'b0) $display("FAIL mmcm_idle_after got busy=%b want 0", busy);
        else n_pass++;
      end
      if (k == 46) begin
        n_total++;
        if (load_en !== therm(8) || busy !== 1'b1)
          $display("FAIL mmcm_restart load_en=%h busy=%b want %h/1", load_en, busy, therm(8));
        else n_pass++;
      end
    end
    mmcm_locked = 1'b1;
  endtask

  task automatic test_arm_drop();
    int el, eb;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      sig_in = (k % 2 == 0);
      arm    = (k < 40);
      tick();
      el = -1; eb = -1;
      case (k)
        40: el = 64;
        41: el = 56;
        44: el = 56;
        45: el = 48;
        67: eb = 1;
        68: eb = 0;
        69: el = 0;
        99: begin el = 0; eb = 0; end
        default: ;
      endcase
      if (el >= 0) begin
        n_total++;
        if (load_en !== therm(el)) $display("FAIL armdrop_load k=%0d got %h want %h", k, load_en, therm(el));
        else n_pass++;
      end
      if (eb >= 0) begin
        n_total++;
        if (busy !== eb[0]) $display("FAIL armdrop_busy k=%0d got %b want %0d", k, busy, eb);
        else n_pass++;
      end
    end
    arm = 1'b1;
  endtask

`ifdef EXCITE_WDOG_EN
  task automatic test_watchdog();
    int el, eb, ef;
    do_reset();
    for (int k = 0; k < 1420; k++) begin
      sig_in    = (k % 2 == 0);
      fault_clr = (k == 1400);
      tick();
      el = -1; eb = -1; ef = -1;
      case (k)
        1052: begin el = 64; ef = 0; end
        1053: ef = 1;
        1054: el = 56;
        1081: begin el = 8; eb = 1; end
        1082: el = 0;
        1200: begin el = 0; eb = 1; end
        1336: eb = 1;
        1337: begin el = 0; eb = 0; end
        1338: eb = 1;
        1339: el = 8;
        1399: ef = 1;
        1400: ef = 0;
        default: ;
      endcase
      if (el >= 0) begin
        n_total++;
        if (load_en !== therm(el)) $display("FAIL wdog_load k=%0d got %h want %h", k, load_en, therm(el));
        else n_pass++;
      end
      if (eb >= 0) begin
        n_total++;
        if (busy !== eb[0]) $display("FAIL wdog_busy k=%0d got %b want %0d", k, busy, eb);
        else n_pass++;
      end
      if (ef >= 0) begin
        n_total++;
        if (fault !== ef[0]) $display("FAIL wdog_fault k=%0d got %b want %0d", k, fault, ef);
        else n_pass++;
      end
    end
    fault_clr = 1'b0;
  endtask
`else
  task automatic test_no_watchdog();
    do_reset();
    for (int k = 0; k < 1200; k++) begin
      sig_in = (k % 2 == 0);
      tick();
      if (k == 1100) begin
        n_total++;
        if (load_en !== therm(64) || fault !== 1'b0)
          $display("FAIL nowdog_on k=%0d load_en=%h fault=%b want %h/0", k, load_en, fault, therm(64));
        else n_pass++;
      end
      if (k == 1199) begin
        n_total++;
        if (busy !== 1'b1) $display("FAIL nowdog_busy got %b want 1", busy);
        else n_pass++;
      end
    end
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n = 1'b0; mmcm_locked = 1'b1; sig_in = 1'b0; arm = 1'b1; fault_clr = 1'b0;
    test_reset();
    test_reset_mid_ramp();
    test_burst();
    test_resume();
    test_mmcm_abort();
    test_arm_drop();
`ifdef EXCITE_WDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
